// File: rtl/bit_tap_defs.sv
// Shared mode encodings and the {vld,dat} stage record for the bit tap pipeline.
// Constants only; no logic, no latency, no backpressure.
package bit_tap_defs;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_RISE = 2'b10;
  localparam logic [1:0] MODE_FALL = 2'b11;

  typedef struct packed {
    logic vld;
    logic dat;
  } tap_t;

endpackage

// File: rtl/bit_tap_stage.sv
// One {vld,dat} pipeline register: one cycle of latency per enabled edge.
// en=0 stalls the stage and it holds its contents.
module bit_tap_stage
  import bit_tap_defs::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  tap_t d,
  output tap_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bit_tap_pipe.sv
// Taps a[sel], conditions it (pass/invert/rise/fall), delays it DEPTH enabled edges, counts valid 1s.
// Latency exactly DEPTH enabled edges; en=0 freezes every stage and prev, cnt_clr still acts.
module bit_tap_pipe
  import bit_tap_defs::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 1,
  parameter int CNT_W = 8,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_vld,
  input  logic [0:WIDTH-1] a,
  input  logic [SEL_W-1:0] sel,
  input  logic [1:0]       mode,
  input  logic             cnt_clr,
  output logic             x,
  output logic             x_vld,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic t;
  logic f;
  logic prev;
  logic inc;
  tap_t stg_d [DEPTH];
  tap_t stg_q [DEPTH];

  // Indices at or beyond WIDTH match no bit, so the tap reads as 0.
  always_comb begin
    t = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel == SEL_W'(i)) t = a[i];
    end
  end

  always_comb begin
    f = t;
    case (mode)
      MODE_PASS: f = t;
      MODE_INV:  f = ~t;
      MODE_RISE: f = t & ~prev;
      MODE_FALL: f = ~t & prev;
      default:   f = t;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else if (en && in_vld) begin
      prev <= t;
    end
  end

  always_comb begin
    stg_d[0] = '{vld: in_vld, dat: in_vld & f};
    for (int k = 1; k < DEPTH; k++) begin
      stg_d[k] = stg_q[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    bit_tap_stage u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .d     (stg_d[k]),
      .q     (stg_q[k])
    );
  end

  assign x     = stg_q[DEPTH-1].dat;
  assign x_vld = stg_q[DEPTH-1].vld;

  // Count on the edge that loads a valid 1 into the last stage, so edge_cnt moves with x.
  assign inc     = en & stg_d[DEPTH-1].vld & stg_d[DEPTH-1].dat;
  assign cnt_sat = (edge_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (cnt_clr) begin
      edge_cnt <= '0;
    end else if (inc && !cnt_sat) begin
      edge_cnt <= edge_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bit_tap_pipe.sv
// Drives four differently parameterised bit_tap_pipe instances from shared stimulus
// and compares each against a per-instance behavioural model.
module tb_bit_tap_pipe;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       in_vld;
  logic       cnt_clr;
  logic [0:5] a;
  logic [2:0] sel;
  logic [1:0] mode;

  logic       x  [N];
  logic       xv [N];
  logic       cs [N];
  logic [7:0] ec0;
  logic [7:0] ec1;
  logic [3:0] ec2;
  logic [3:0] ec3;

  int width_of [N] = '{4, 4, 4, 6};
  int depth_of [N] = '{1, 3, 2, 3};
  int cntw_of  [N] = '{8, 8, 4, 4};
  int selw_of  [N] = '{2, 2, 2, 3};

  int pv     [N][3];
  int pd     [N][3];
  int prev_m [N];
  int cnt_m  [N];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bit_tap_pipe #(.WIDTH(4), .DEPTH(1), .CNT_W(8), .SEL_W(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_vld(in_vld), .a(a[0:3]), .sel(sel[1:0]),
    .mode(mode), .cnt_clr(cnt_clr), .x(x[0]), .x_vld(xv[0]), .edge_cnt(ec0), .cnt_sat(cs[0]));

  bit_tap_pipe #(.WIDTH(4), .DEPTH(3), .CNT_W(8), .SEL_W(2)) u_d3 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_vld(in_vld), .a(a[0:3]), .sel(sel[1:0]),
    .mode(mode), .cnt_clr(cnt_clr), .x(x[1]), .x_vld(xv[1]), .edge_cnt(ec1), .cnt_sat(cs[1]));

  bit_tap_pipe #(.WIDTH(4), .DEPTH(2), .CNT_W(4), .SEL_W(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_vld(in_vld), .a(a[0:3]), .sel(sel[1:0]),
    .mode(mode), .cnt_clr(cnt_clr), .x(x[2]), .x_vld(xv[2]), .edge_cnt(ec2), .cnt_sat(cs[2]));

  bit_tap_pipe #(.WIDTH(6), .DEPTH(3), .CNT_W(4), .SEL_W(3)) u_w6 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_vld(in_vld), .a(a), .sel(sel),
    .mode(mode), .cnt_clr(cnt_clr), .x(x[3]), .x_vld(xv[3]), .edge_cnt(ec3), .cnt_sat(cs[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_cnt(int i);
    case (i)
      0:       return 32'(ec0);
      1:       return 32'(ec1);
      2:       return 32'(ec2);
      default: return 32'(ec3);
    endcase
  endfunction

  function automatic int tap_of(int i);
    int s = int'(sel) & ((1 << selw_of[i]) - 1);
    if (s >= width_of[i]) return 0;
    return (a[s] === 1'b1) ? 1 : 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      prev_m[i] = 0;
      cnt_m[i]  = 0;
      for (int k = 0; k < 3; k++) begin
        pv[i][k] = 0;
        pd[i][k] = 0;
      end
    end
  endfunction

  // One rising edge with reset released: sample enters the delay line, counter sees its tail.
  function automatic void model_edge();
    for (int i = 0; i < N; i++) begin
      int t   = tap_of(i);
      int f   = 0;
      int inc = 0;
      int d   = depth_of[i];
      int mx  = (1 << cntw_of[i]) - 1;
      case (mode)
        2'b00:   f = t;
        2'b01:   f = 1 - t;
        2'b10:   f = (t == 1 && prev_m[i] == 0) ? 1 : 0;
        default: f = (t == 0 && prev_m[i] == 1) ? 1 : 0;
      endcase
      if (en) begin
        for (int k = d - 1; k > 0; k--) begin
          pv[i][k] = pv[i][k-1];
          pd[i][k] = pd[i][k-1];
        end
        pv[i][0] = in_vld ? 1 : 0;
        pd[i][0] = in_vld ? f : 0;
        inc = (pv[i][d-1] == 1 && pd[i][d-1] == 1) ? 1 : 0;
        if (in_vld) prev_m[i] = t;
      end
      if (cnt_clr) cnt_m[i] = 0;
      else if (inc == 1 && cnt_m[i] < mx) cnt_m[i]++;
    end
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      int d  = depth_of[i];
      int mx = (1 << cntw_of[i]) - 1;
      chk($sformatf("%s.x%0d", tag, i),    32'(x[i]),  pd[i][d-1]);
      chk($sformatf("%s.xv%0d", tag, i),   32'(xv[i]), pv[i][d-1]);
      chk($sformatf("%s.cnt%0d", tag, i),  get_cnt(i), cnt_m[i]);
      chk($sformatf("%s.sat%0d", tag, i),  32'(cs[i]), (cnt_m[i] == mx) ? 1 : 0);
    end
  endtask

  // Entered at a falling edge with inputs already set; returns at the next falling edge.
  task automatic cyc(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic feed(input string tag, input int n);
    for (int j = 0; j < n; j++) cyc(tag);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; in_vld = 1'b1; cnt_clr = 1'b0;
    a = '1; sel = 3'd0; mode = 2'b00;
    model_reset();
    #2;
    check_all("rst_async");
    @(negedge clk);
    feed("rst_hold", 3);
    rst_n = 1'b1;
    feed("rst_rel", 4);

    // Legacy registered inverter on the MSB.
    do_reset("legacy_rst");
    mode = 2'b01; sel = 3'd0;
    for (int v = 0; v < 16; v++) begin
      a[0:3] = 4'(v);
      a[4:5] = 2'b00;
      cyc("legacy");
    end
    in_vld = 1'b0;
    cyc("legacy_tail");
    chk("legacy_cnt", 32'(ec0), 32'd8);

    // Latency through three stages, then the same with a two-edge stall.
    do_reset("lat_rst");
    mode = 2'b00; sel = 3'd2; a = 6'b001000; in_vld = 1'b1;
    cyc("lat");
    in_vld = 1'b0;
    feed("lat", 1);
    cyc("lat");
    chk("lat3_x", 32'({x[1], xv[1]}), 32'd3);
    cyc("lat");
    chk("lat4_xv", 32'(xv[1]), 32'd0);

    do_reset("stall_rst");
    in_vld = 1'b1;
    cyc("stall");
    in_vld = 1'b0; en = 1'b0;
    feed("stall", 2);
    en = 1'b1;
    feed("stall", 2);
    chk("stall5_xv", 32'({x[1], xv[1]}), 32'd3);
    en = 1'b0;
    feed("stall_hold", 2);
    chk("stall_hold_xv", 32'(xv[1]), 32'd1);
    en = 1'b1;

    // Rise then fall detection on a[3] = 0,1,1,0,1.
    for (int m = 2; m < 4; m++) begin
      int seq [5] = '{0, 1, 1, 0, 1};
      do_reset("edge_rst");
      mode = 2'(m); sel = 3'd3; in_vld = 1'b1;
      for (int j = 0; j < 5; j++) begin
        a = '0;
        a[3] = seq[j][0];
        cyc(m == 2 ? "rise" : "fall");
      end
      in_vld = 1'b0;
      feed("edge_tail", 2);
      chk(m == 2 ? "rise_cnt" : "fall_cnt", 32'(ec2), (m == 2) ? 32'd2 : 32'd1);
    end

    // Saturation and clear priority on the 4-bit counters.
    do_reset("sat_rst");
    mode = 2'b00; sel = 3'd0; a = '1; in_vld = 1'b1;
    feed("sat", 20);
    chk("sat_cnt", 32'(ec2), 32'd15);
    chk("sat_flag", 32'(cs[2]), 32'd1);
    cnt_clr = 1'b1;
    cyc("clr");
    chk("clr_cnt", 32'(ec2), 32'd0);
    cnt_clr = 1'b0;
    cyc("clr_next");
    chk("clr_next_cnt", 32'(ec2), 32'd1);

    // Reset pulse with valid ones in flight.
    do_reset("mid_rst0");
    feed("mid_fill", 3);
    do_reset("mid_arst");
    chk("mid_arst_xv", 32'(xv[1]), 32'd0);
    in_vld = 1'b0;
    feed("mid_after", 4);

    // Out-of-range index on the 6-bit instance reads as 0.
    mode = 2'b01; sel = 3'd7; a = '1; in_vld = 1'b1;
    feed("oor", 3);
    chk("oor_x", 32'({x[3], xv[3]}), 32'd3);

    // Random traffic with stalls, bubbles and occasional clears.
    for (int j = 0; j < 400; j++) begin
      en      = ($urandom_range(0, 9) != 0);
      in_vld  = ($urandom_range(0, 3) != 0);
      a       = 6'($urandom);
      sel     = 3'($urandom);
      mode    = 2'($urandom);
      cnt_clr = ($urandom_range(0, 40) == 0);
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit_tap_pipe.md
Name: bit_tap_pipe

Overview:
Parametrised successor to the single-bit registered inverter used in the a1 lab benches. Selects one bit of a WIDTH-bit input vector and applies one of four modes: pass, invert, rise-detect or fall-detect. The result passes through a DEPTH-stage stallable pipeline with valid tracking. A saturating counter counts valid 1 outputs. It is the block that lab benches and later datapath exercises instantiate to tap, condition and delay a control bit.

Parameters:
WIDTH, 4, input vector width (>=1); bit 0 is leftmost/MSB ([0:WIDTH-1] ordering)
DEPTH, 1, pipeline stages = latency in cycles (>=1)
CNT_W, 8, edge_cnt width (>=1)
SEL_W, 2, sel width; must satisfy 2**SEL_W >= WIDTH

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
en  in  1  pipeline advance; 0 = stall (all stages and prev hold)
in_vld  in  1  input sample valid
a  in  [0:WIDTH-1]  input vector
sel  in  SEL_W  bit index into a
mode  in  2  00 pass, 01 invert, 10 rise-detect, 11 fall-detect
cnt_clr  in  1  synchronous counter clear
x  out  1  tapped/conditioned bit after DEPTH stages
x_vld  out  1  x is valid
edge_cnt  out  CNT_W  saturating count of valid 1 outputs
cnt_sat  out  1  edge_cnt == all ones

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately): all stage bits/valids=0, prev=0, edge_cnt=0. Outputs x=0, x_vld=0, edge_cnt=0, cnt_sat=0. Reset mid-flight discards in-flight data. After release, the first x_vld=1 occurs DEPTH accepted cycles after the first in_vld.
- Tap: t = a[sel]. If sel >= WIDTH, t = 0.
- Accept condition: en=1 and in_vld=1 at a rising edge. On accept, prev <= t. prev holds otherwise.
- Mode function f, evaluated combinationally on the current a/sel/mode/prev:
  - 00: f = t
  - 01: f = ~t (DEPTH=1 reproduces the legacy registered ~a[0])
  - 10: f = t & ~prev
  - 11: f = ~t & prev
- mode and sel apply per sample. Changing them mid-stream affects only samples accepted after the change. There is no flush.
- Pipeline when en=1:
  - stage0 <= {in_vld, in_vld ? f : 0}
  - stage k <= stage k-1
  - A bubble (in_vld=0) carries vld=0, bit=0.
- Pipeline when en=0: every stage holds. x and x_vld are frozen.
- Outputs: x = stage[DEPTH-1].bit, x_vld = stage[DEPTH-1].vld. Both are registered with no combinational path from inputs. Latency is exactly DEPTH enabled edges.
- Counter:
  - Increment on an edge where en=1 and the value loading into stage[DEPTH-1] has vld=1 and bit=1. edge_cnt therefore updates on the same edge that x becomes a valid 1.
  - Saturates at 2**CNT_W-1; no wrap.
  - cnt_clr=1 sets edge_cnt to 0 on the next edge, regardless of en. Clear has priority over a simultaneous increment.
- cnt_sat is combinational from edge_cnt.

Decomposition:
- Shared defs file bit_tap_defs: mode constants MODE_PASS=2'b00, MODE_INV=2'b01, MODE_RISE=2'b10, MODE_FALL=2'b11.
- Sub-module bit_tap_stage: one {vld,bit} register with en and async active-low reset. Instantiated DEPTH times via generate.
- Mode logic, prev register and counter live in bit_tap_pipe.

Test Plan:
1. Reset: rst_n=0 with en=1, in_vld=1, a=4'b1111 -> x=0, x_vld=0, edge_cnt=0 throughout. After release, x_vld stays 0 for the first DEPTH edges.
2. Legacy (DEPTH=1, mode=01, sel=0, en=1, in_vld=1): a steps 0000..1111, one per cycle. -> One edge later x=1 for 0000..0111 and x=0 for 1000..1111; edge_cnt=8.
3. Latency/stall (DEPTH=3, mode=00, sel=2): a=0010 with in_vld=1 for one cycle, then in_vld=0.
   - With en=1 throughout: x=1, x_vld=1 on the 3rd edge, then x_vld=0.
   - With en=0 for 2 edges mid-flight: the valid 1 appears on the 5th edge and holds during the stall.
4. Rise/fall (DEPTH=2, sel=3): a[3] sequence 0,1,1,0,1.
   - mode=10 -> x = 0,1,0,0,1 (2 edges delayed); edge_cnt=2.
   - Same sequence with mode=11 after reset -> x = 0,0,0,1,0.
5. Saturation/clear (CNT_W=4, mode=00, a[sel]=1): 20 accepted samples -> edge_cnt=15, cnt_sat=1. Assert cnt_clr on an incrementing edge -> edge_cnt=0. Next valid 1 -> edge_cnt=1.
6. Async reset mid-flight and out-of-range sel:
   - DEPTH=3 with 3 valid 1s in flight, pulse rst_n low between edges -> x_vld drops to 0 immediately; no stale outputs after release.
   - WIDTH=6, SEL_W=3, sel=7, mode=01 -> x=1 (t forced to 0).
